// File: rtl/axis_slave_uart_tx.sv
// AXI-Stream word sink: buffers words in a FIFO and serializes each one LSB byte first to the UART byte port.
// Latency: first byte valid one cycle after acceptance (empty FIFO, idle serializer); 1 byte/cycle with ready high.
// Backpressure: TREADY low while the FIFO is full; po_tx_data/po_tx_valid held stable until pi_tx_ready.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_vld) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign level  = wr_ptr - rd_ptr;
endmodule

module axis_slave_uart_tx #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 4
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    output logic [7:0]                          po_tx_data,
    output logic                                po_tx_valid,
    input  logic                                pi_tx_ready,
    output logic                                po_frame_done,
    output logic [$clog2(C_FIFO_DEPTH):0]       po_fifo_level
);
    localparam int NBYTES = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LVLW   = $clog2(C_FIFO_DEPTH) + 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [LVLW-1:0] LVL_FULL = LVLW'(C_FIFO_DEPTH);

    typedef struct packed {
        logic                   last;
        logic [NBYTES-1:0]      strb;
        logic [NBYTES-1:0][7:0] data;
    } word_t;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    word_t           in_word, head_word, word_q, word_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            frame_done_q, frame_done_d;
    logic            rst_done_q;
    logic            push, pop, fifo_empty;
    logic [LVLW-1:0] level;
    logic            cur_vld;
    logic [7:0]      cur_dat;

    always_comb begin
        in_word      = '0;
        in_word.last = S_AXIS_TLAST;
        in_word.strb = S_AXIS_TSTRB;
        in_word.data = S_AXIS_TDATA;
    end

    sync_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (C_FIFO_DEPTH)
    ) u_word_fifo (
        .clk    (S_AXIS_ACLK),
        .arst_n (S_AXIS_ARESETN),
        .wr_vld (push),
        .wr_dat (in_word),
        .rd_vld (pop),
        .rd_dat (head_word),
        .level  (level)
    );

    // Ready depends only on registered state; a full FIFO never admits a word, even on a pop cycle.
    assign S_AXIS_TREADY = rst_done_q && (level != LVL_FULL);
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign fifo_empty    = (level == '0);

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            rst_done_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        cur_vld      = 1'b0;
        cur_dat      = 8'h00;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = head_word;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                cur_vld = word_q.strb[idx_q];
                cur_dat = word_q.data[idx_q];
                // Disabled byte lanes advance without a handshake, one cycle each.
                if (!cur_vld || pi_tx_ready) begin
                    if (idx_q == IDX_LAST) begin
                        frame_done_d = word_q.last;
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            word_d = head_word;
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign po_tx_valid   = cur_vld;
    assign po_tx_data    = cur_dat;
    assign po_frame_done = frame_done_q;
    assign po_fifo_level = level;
endmodule

// File: tb/tb_axis_slave_uart_tx.sv
// Randomized and directed bench for axis_slave_uart_tx with a byte-stream scoreboard.
module tb_axis_slave_uart_tx;
    localparam int W     = 32;
    localparam int NB    = W / 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [W-1:0]  s_tdata;
    logic [NB-1:0] s_tstrb;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          frame_done;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    axis_slave_uart_tx #(
        .C_S_AXIS_TDATA_WIDTH (W),
        .C_FIFO_DEPTH         (DEPTH)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (arst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TSTRB   (s_tstrb),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .po_tx_data     (tx_data),
        .po_tx_valid    (tx_valid),
        .pi_tx_ready    (tx_ready),
        .po_frame_done  (frame_done),
        .po_fifo_level  (level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: accepted words expand into an ordered byte stream; each TLAST
    // word marks the cumulative byte count at which its frame_done pulse is due.
    logic [7:0] exp_q[$];
    int         frame_q[$];
    int         hs_edges[$];
    int         fd_cycs[$];
    int         cyc = 0;
    int         bytes_in = 0;
    int         bytes_out = 0;
    int         n_fd = 0;
    int         last_accept = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] held_dat = 8'h00;
    int         rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy_mode == 1)      tx_ready = ~tx_ready;
        else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
    end

    // Samples mid-cycle: state after edge cyc, handshakes land on edge cyc+1.
    always @(negedge clk) begin
        #2;
        if (!arst_n) begin
            exp_q.delete();
            frame_q.delete();
            bytes_in   = bytes_out;
            stall_prev = 1'b0;
        end else begin
            if (frame_done) begin
                fd_cycs.push_back(cyc);
                n_fd++;
                check("fd_expected", frame_q.size() != 0, 1);
                if (frame_q.size() != 0) check("fd_position", bytes_out, frame_q.pop_front());
            end
            if (stall_prev) begin
                check("hold_vld", tx_valid, 1);
                check("hold_dat", tx_data, held_dat);
            end
            stall_prev = tx_valid && !tx_ready;
            held_dat   = tx_data;
            if (tx_valid && tx_ready) begin
                hs_edges.push_back(cyc + 1);
                check("tx_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
                bytes_out++;
            end
            if (s_tvalid && s_tready) begin
                last_accept = cyc + 1;
                for (int i = 0; i < NB; i++) begin
                    if (s_tstrb[i]) begin
                        exp_q.push_back(s_tdata[8*i +: 8]);
                        bytes_in++;
                    end
                end
                if (s_tlast) frame_q.push_back(bytes_in);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with TVALID still high.
    task automatic push(input logic [W-1:0] d, input logic [NB-1:0] s, input logic l);
        int t = 0;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        while (!s_tready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("push_timeout", t < 1000, 1);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        #3;
        while ((exp_q.size() != 0 || frame_q.size() != 0 || level != 0 || tx_valid) && t < 3000) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("drain_timeout", t < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w0;
        int b0, f0, a0;
        arst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tlast = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tready", s_tready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        arst_n = 1'b1;
        #1 check("tready_before_edge", s_tready, 0);
        @(negedge clk);
        #1 check("tready_after_edge", s_tready, 1);
        @(negedge clk);

        // Full word, ready held high: four consecutive bytes, then one frame pulse.
        tx_ready = 1'b1;
        hs_edges.delete(); fd_cycs.delete();
        push(32'h44332211, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        #1;
        check("t1_level", level, 1);
        check("t1_no_early_vld", tx_valid, 0);
        repeat (8) @(negedge clk);
        check("t1_nbytes", hs_edges.size(), 4);
        for (int i = 0; i < hs_edges.size(); i++) check("t1_byte_edge", hs_edges[i], last_accept + 2 + i);
        check("t1_nfd", fd_cycs.size(), 1);
        if (fd_cycs.size() != 0) check("t1_fd_cycle", fd_cycs[0], last_accept + 5);

        // Sparse strobe: bytes 0 and 2 only, skipped lanes still cost a cycle.
        hs_edges.delete(); fd_cycs.delete();
        push(32'hAABBCCDD, 4'h5, 1'b0);
        s_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        check("t2_nbytes", hs_edges.size(), 2);
        if (hs_edges.size() == 2) begin
            check("t2_edge0", hs_edges[0], last_accept + 2);
            check("t2_edge1", hs_edges[1], last_accept + 4);
        end
        check("t2_nfd", fd_cycs.size(), 0);

        // Burst of five with the UART stalled: one word in the serializer, four fill the FIFO.
        tx_ready = 1'b0;
        b0 = bytes_out;
        w0 = $urandom;
        push(w0, 4'hF, 1'b0);
        for (int i = 1; i < 5; i++) push($urandom, 4'hF, 1'(i == 4));
        s_tvalid = 1'b0;
        #1;
        check("t3_tready_full", s_tready, 0);
        check("t3_level_full", level, DEPTH);
        check("t3_first_vld", tx_valid, 1);
        check("t3_first_dat", tx_data, w0[7:0]);
        repeat (5) @(negedge clk);
        tx_ready = 1'b1;
        a0 = 0;
        #1;
        while (!s_tready && a0 < 100) begin
            @(negedge clk);
            #1;
            a0++;
        end
        check("t3_tready_back", s_tready, 1);
        check("t3_bytes_at_pop", bytes_out - b0, 4);
        @(negedge clk);
        wait_drain();
        check("t3_total_bytes", bytes_out - b0, 20);

        // Ready toggling every cycle across a two-word frame.
        b0 = bytes_out; f0 = n_fd;
        rdy_mode = 1;
        push($urandom, 4'hF, 1'b0);
        push($urandom, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        wait_drain();
        check("t4_bytes", bytes_out - b0, 8);
        check("t4_frames", n_fd - f0, 1);
        rdy_mode = 0;
        tx_ready = 1'b1;
        @(negedge clk);

        // All-zero strobe with TLAST: no bytes, pulse after NB skipped lanes.
        hs_edges.delete(); fd_cycs.delete();
        b0 = bytes_out;
        push($urandom, 4'h0, 1'b1);
        s_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_bytes", bytes_out - b0, 0);
        check("t5_nfd", fd_cycs.size(), 1);
        if (fd_cycs.size() != 0) check("t5_fd_cycle", fd_cycs[0], last_accept + NB + 1);

        // Reset with byte 2 pending and two words queued.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push($urandom, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        b0 = bytes_out;
        tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        #3;
        check("t6_bytes_before_rst", bytes_out - b0, 2);
        arst_n = 1'b0;
        #1;
        check("t6_rst_vld", tx_valid, 0);
        check("t6_rst_tready", s_tready, 0);
        check("t6_rst_level", level, 0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t6_level_after", level, 0);
        check("t6_no_stale", bytes_out - b0, 2);
        @(negedge clk);
        b0 = bytes_out;
        push($urandom, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        wait_drain();
        check("t6_new_word", bytes_out - b0, NB);

        // Random traffic with random UART backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 120; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                s_tvalid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            push($urandom, NB'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
        end
        s_tvalid = 1'b0;
        wait_drain();
        check("rand_bytes_left", exp_q.size(), 0);
        check("rand_frames_left", frame_q.size(), 0);
        check("rand_bytes_total", bytes_out, bytes_in);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
